memory_access_arbiter: RTL and testbench
========================================

Name: memory_access_arbiter

Overview:
- Shares the single read/write port of the memory backend between two data requesters.
  - Port 0: core load/store unit.
  - Port 1: debug/DMA.
- Sequences byte, halfword and word accesses onto the word-wide backend, using read-modify-write for sub-word stores.
- Sits between the requesters and the backend address/data/write-enable signals.
- The backend instruction-fetch port connects directly to fetch and does not pass through this block.

Parameters:
- NUM_REQ, 2, number of requesters. Fixed at 2; other values are unsupported.
- ADDR_W, 32, requester byte-address width. The backend word address is [ADDR_W-1:2].

Ports:
- clock  in  1  single system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- reqN_valid  in  1  request pending (N = 0, 1)
- reqN_address  in  32  byte address
- reqN_write  in  1  1 = store, 0 = load
- reqN_size  in  2  0 = byte, 1 = half, 2 = word; 3 = illegal, treated as misaligned
- reqN_unsigned  in  1  loads only; 1 = zero-extend, 0 = sign-extend
- reqN_wdata  in  32  store data, right-aligned
- reqN_ready  out  1  accept strobe; high only in the cycle the request is taken
- reqN_done  out  1  one-cycle completion pulse
- reqN_rdata  out  32  load result; valid while reqN_done is high
- reqN_error  out  1  misaligned/illegal flag; valid while reqN_done is high
- backendAddress  out  30  word address to backend
- backendDataOut  in  32  backend read data, one cycle after the address is presented
- backendDataIn  out  32  backend write data
- backendWriteEnable  out  1  backend write strobe

Behaviour:
- States: IDLE, ISSUE, CAPTURE, WRITEBACK, RESPOND.
- IDLE:
  - If any reqN_valid is high, grant one requester and assert its reqN_ready combinationally in that cycle.
  - Latch address, write, size, unsigned and wdata into request registers.
  - If misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size=3), go to RESPOND with error=1 and no backend access.
  - Otherwise go to ISSUE.
- ISSUE:
  - Drive backendAddress = latched addr[31:2].
  - Word store: backendWriteEnable=1 and backendDataIn=wdata, then go to RESPOND.
  - All other accesses: go to CAPTURE.
- CAPTURE:
  - Keep backendAddress driven; backendDataOut is valid in this cycle.
  - Load: extract the lane selected by addr[1:0] and extend it per the unsigned flag into the rdata register, then go to RESPOND.
  - Sub-word store: merge wdata into the selected lane(s) of backendDataOut into a merge register, then go to WRITEBACK.
- WRITEBACK: backendWriteEnable=1, backendDataIn=merge register, then go to RESPOND.
- RESPOND: pulse done for the granted requester; rdata and error are valid; go to IDLE.
- Latency, with acceptance at cycle T:

  | Access | Backend write | done |
  |---|---|---|
  | Misaligned | none | T+1 |
  | Word store | T+1 | T+2 |
  | Load | none | T+3 |
  | Sub-word store | T+3 | T+4 |

- Throughput: one transaction in flight. A new grant is possible only in IDLE, i.e. the cycle after RESPOND.
- Lanes: byte lane = addr[1:0]; half lane = addr[1]; little-endian.
- Requester contract:
  - Request fields must be held stable only until reqN_ready.
  - Dropping valid before ready withdraws the request.
- Reset values: state IDLE; all ready/done/error outputs 0; rdata 0; backendAddress 0; backendDataIn 0; backendWriteEnable 0; last-grant pointer = 1.
- Reset mid-operation:
  - backendWriteEnable is gated low whenever reset is high.
  - The transaction is abandoned with no done pulse.
  - A half-completed RMW leaves memory unmodified.
- Simultaneous valid on both ports: resolved by the arbitration policy (see Optional Feature). The loser's ready stays 0 and it retries in the next IDLE.
- Outputs to the non-granted requester stay 0.

Optional Feature:
- Macro: MEMORY_ARBITER_ROUND_ROBIN_EN.
- Defined: round-robin. On a conflict, grant the port not granted last; the last-grant pointer updates on each grant.
- Undefined: fixed priority, port 0 always wins; the pointer is removed.

Decomposition:
- Package memory_arbiter_pkg holds:
  - access_size_t enum (BYTE, HALF, WORD)
  - arb_state_t enum
  - the misalignment-check function
- Sub-module subword_lane_unit: purely combinational. Inputs are word, addr[1:0], size, unsigned and wdata. Outputs are the extended load value and the merged store word.

Test Plan:
- Port 0 loads byte 0x103, unsigned=0, memory word 0x100 = 0x80FF_1234 -> backendAddress 0x40 at T+1; req0_rdata = 0xFFFF_FF80 with req0_done at T+3.
- Port 1 stores half 0xBEEF at 0x202, memory word = 0x1122_3344 -> write 0xBEEF_3344 at T+3; req1_done at T+4.
- Port 0 stores word 0xDEAD_BEEF at 0x10 -> backendWriteEnable at T+1 with data 0xDEAD_BEEF; done at T+2.
- Port 0 loads word at 0x06 -> req0_error=1 and done at T+1; no backendWriteEnable and no memory change.
- Both ports request continuously from reset:
  - Round-robin build: grants 0, 1, 0, 1.
  - Fixed-priority build: grants 0, 0, 0.
- Reset asserted in WRITEBACK of a byte store -> backendWriteEnable=0 in that cycle; no done pulse; memory word unchanged; state IDLE next cycle.

Source files
------------

// File: rtl/memory_arbiter_pkg.sv
// Shared types and helpers for the memory access arbiter: access sizes,
// controller states and the alignment rule applied at request acceptance.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } access_size_t;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        WRITEBACK,
        RESPOND
    } arb_state_t;

    // Size code 3 has no enum member and falls into the default branch.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            BYTE:    return 1'b0;
            HALF:    return addr_lo[0];
            WORD:    return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/subword_lane_unit.sv
// Combinational lane steering: extracts and extends a load lane from a
// backend word, and merges store data into the selected lane(s).
module subword_lane_unit
    import memory_arbiter_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] load_value,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        sign_fill;

    assign byte_sel = word[{lane, 3'b000} +: 8];
    assign half_sel = word[{lane[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
        load_value = word;
        sign_fill  = 1'b0;
        case (size)
            BYTE: begin
                sign_fill  = ~is_unsigned & byte_sel[7];
                load_value = {{24{sign_fill}}, byte_sel};
            end
            HALF: begin
                sign_fill  = ~is_unsigned & half_sel[15];
                load_value = {{16{sign_fill}}, half_sel};
            end
            default: load_value = word;
        endcase
    end

    // Little-endian: byte lane n occupies bits [8n+7:8n].
    always_comb begin
        store_word = word;
        case (size)
            BYTE:    store_word[{lane, 3'b000} +: 8]     = wdata[7:0];
            HALF:    store_word[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            default: store_word = wdata;
        endcase
    end

endmodule

// File: rtl/memory_access_arbiter.sv
// Shares one word-wide memory backend between two requesters, with RMW for sub-word stores.
// Define MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module memory_access_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_address,
    input  logic              req0_write,
    input  logic [1:0]        req0_size,
    input  logic              req0_unsigned,
    input  logic [31:0]       req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [31:0]       req0_rdata,
    output logic              req0_error,

    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_address,
    input  logic              req1_write,
    input  logic [1:0]        req1_size,
    input  logic              req1_unsigned,
    input  logic [31:0]       req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [31:0]       req1_rdata,
    output logic              req1_error,

    output logic [ADDR_W-3:0] backendAddress,
    input  logic [31:0]       backendDataOut,
    output logic [31:0]       backendDataIn,
    output logic              backendWriteEnable
);

    arb_state_t         state;
    logic [NUM_REQ-1:0] valid_vec;
    logic               grant_any;
    logic               grant_sel;
    logic               grant_id;

    logic [ADDR_W-1:0]  sel_address;
    logic               sel_write;
    logic [1:0]         sel_size;
    logic               sel_unsigned;
    logic [31:0]        sel_wdata;

    logic [ADDR_W-1:0]  req_address;
    logic               req_write;
    logic [1:0]         req_size;
    logic               req_unsigned;
    logic [31:0]        req_wdata;

    logic               done_q;
    logic               error_q;
    logic               we_q;
    logic [31:0]        rdata_q;
    logic [31:0]        data_in_q;

    logic [31:0]        load_value;
    logic [31:0]        store_word;

`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
    logic               last_grant;
`endif

    assign valid_vec = {req1_valid, req0_valid};

    // Grants are only offered in IDLE and never while reset is held.
    always_comb begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
        if (state == IDLE && !reset) begin
            grant_any = |valid_vec;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            if (&valid_vec) grant_sel = ~last_grant;
            else            grant_sel = valid_vec[1];
`else
            grant_sel = ~valid_vec[0] & valid_vec[1];
`endif
        end
    end

    assign sel_address  = grant_sel ? req1_address  : req0_address;
    assign sel_write    = grant_sel ? req1_write    : req0_write;
    assign sel_size     = grant_sel ? req1_size     : req0_size;
    assign sel_unsigned = grant_sel ? req1_unsigned : req0_unsigned;
    assign sel_wdata    = grant_sel ? req1_wdata    : req0_wdata;

    subword_lane_unit u_lane (
        .word        (backendDataOut),
        .lane        (req_address[1:0]),
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .wdata       (req_wdata),
        .load_value  (load_value),
        .store_word  (store_word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: request registers are reset too, because backendAddress is driven straight from them.
            state        <= IDLE;
            grant_id     <= 1'b0;
            req_address  <= '0;
            req_write    <= 1'b0;
            req_size     <= BYTE;
            req_unsigned <= 1'b0;
            req_wdata    <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            we_q         <= 1'b0;
            rdata_q      <= '0;
            data_in_q    <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
            last_grant   <= 1'b1;
`endif
        end else begin
            done_q <= 1'b0;
            we_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        grant_id     <= grant_sel;
                        req_address  <= sel_address;
                        req_write    <= sel_write;
                        req_size     <= sel_size;
                        req_unsigned <= sel_unsigned;
                        req_wdata    <= sel_wdata;
                        rdata_q      <= '0;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
                        last_grant   <= grant_sel;
`endif
                        if (is_misaligned(sel_size, sel_address[1:0])) begin
                            error_q <= 1'b1;
                            done_q  <= 1'b1;
                            state   <= RESPOND;
                        end else begin
                            error_q <= 1'b0;
                            state   <= ISSUE;
                            // Word stores write in ISSUE, so their strobe is armed now.
                            if (sel_write && sel_size == WORD) begin
                                we_q      <= 1'b1;
                                data_in_q <= sel_wdata;
                            end
                        end
                    end
                end
                ISSUE: begin
                    if (req_write && req_size == WORD) begin
                        done_q <= 1'b1;
                        state  <= RESPOND;
                    end else begin
                        state  <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (req_write) begin
                        data_in_q <= store_word;
                        we_q      <= 1'b1;
                        state     <= WRITEBACK;
                    end else begin
                        rdata_q   <= load_value;
                        done_q    <= 1'b1;
                        state     <= RESPOND;
                    end
                end
                WRITEBACK: begin
                    done_q <= 1'b1;
                    state  <= RESPOND;
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign req0_ready = grant_any & ~grant_sel;
    assign req1_ready = grant_any &  grant_sel;

    assign req0_done  = done_q & ~grant_id;
    assign req1_done  = done_q &  grant_id;
    assign req0_error = req0_done & error_q;
    assign req1_error = req1_done & error_q;
    assign req0_rdata = {32{req0_done}} & rdata_q;
    assign req1_rdata = {32{req1_done}} & rdata_q;

    // Gating with reset keeps an interrupted RMW from reaching memory.
    assign backendAddress     = req_address[ADDR_W-1:2];
    assign backendDataIn      = data_in_q;
    assign backendWriteEnable = we_q & ~reset;

endmodule

// File: tb/tb_memory_access_arbiter.sv
// Directed bench for memory_access_arbiter with a one-cycle-latency backend memory model.
module tb_memory_access_arbiter;

    logic        clock = 1'b0;
    logic        reset;

    logic        req0_valid, req0_write, req0_unsigned, req0_ready, req0_done, req0_error;
    logic [31:0] req0_address, req0_wdata, req0_rdata;
    logic [1:0]  req0_size;
    logic        req1_valid, req1_write, req1_unsigned, req1_ready, req1_done, req1_error;
    logic [31:0] req1_address, req1_wdata, req1_rdata;
    logic [1:0]  req1_size;

    logic [29:0] backendAddress;
    logic [31:0] backendDataOut, backendDataIn;
    logic        backendWriteEnable;

    logic [31:0] mem [0:255];
    logic        poke_en;
    logic [7:0]  poke_addr;
    logic [31:0] poke_data;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clock = ~clock;

    memory_access_arbiter dut (
        .clock              (clock),
        .reset              (reset),
        .req0_valid         (req0_valid),
        .req0_address       (req0_address),
        .req0_write         (req0_write),
        .req0_size          (req0_size),
        .req0_unsigned      (req0_unsigned),
        .req0_wdata         (req0_wdata),
        .req0_ready         (req0_ready),
        .req0_done          (req0_done),
        .req0_rdata         (req0_rdata),
        .req0_error         (req0_error),
        .req1_valid         (req1_valid),
        .req1_address       (req1_address),
        .req1_write         (req1_write),
        .req1_size          (req1_size),
        .req1_unsigned      (req1_unsigned),
        .req1_wdata         (req1_wdata),
        .req1_ready         (req1_ready),
        .req1_done          (req1_done),
        .req1_rdata         (req1_rdata),
        .req1_error         (req1_error),
        .backendAddress     (backendAddress),
        .backendDataOut     (backendDataOut),
        .backendDataIn      (backendDataIn),
        .backendWriteEnable (backendWriteEnable)
    );

    // Backend: synchronous write, read data one cycle after the address.
    always @(posedge clock) begin
        if (poke_en)                 mem[poke_addr] <= poke_data;
        else if (backendWriteEnable) mem[backendAddress[7:0]] <= backendDataIn;
        backendDataOut <= mem[backendAddress[7:0]];
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    task automatic idle_inputs();
        req0_valid = 0; req0_address = '0; req0_write = 0; req0_size = '0; req0_unsigned = 0; req0_wdata = '0;
        req1_valid = 0; req1_address = '0; req1_write = 0; req1_size = '0; req1_unsigned = 0; req1_wdata = '0;
    endtask

    // Presents one request while the DUT is idle and records what happens in the following cycles.
    task automatic run_access(input int port, input logic [31:0] addr, input logic wr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata,
                              output logic accepted, output logic [29:0] addr_t1,
                              output int we_cyc, output logic [31:0] we_data,
                              output int done_cyc, output logic [31:0] rdata, output logic err, output logic stray);
        accepted = 0; addr_t1 = '0; we_cyc = -1; we_data = '0; done_cyc = -1; rdata = '0; err = 0; stray = 0;
        if (port == 0) begin
            req0_valid = 1; req0_address = addr; req0_write = wr; req0_size = size; req0_unsigned = uns; req0_wdata = wdata;
        end else begin
            req1_valid = 1; req1_address = addr; req1_write = wr; req1_size = size; req1_unsigned = uns; req1_wdata = wdata;
        end
        #1;
        accepted = (port == 0) ? (req0_ready && !req1_ready) : (req1_ready && !req0_ready);
        tick();
        req0_valid = 0; req1_valid = 0;
        for (int c = 1; c <= 8 && done_cyc < 0; c++) begin
            if (c == 1) addr_t1 = backendAddress;
            if (backendWriteEnable) begin we_cyc = c; we_data = backendDataIn; end
            if ((port == 0) ? req1_done : req0_done) stray = 1;
            if ((port == 0) ? req0_done : req1_done) begin
                done_cyc = c;
                rdata    = (port == 0) ? req0_rdata : req1_rdata;
                err      = (port == 0) ? req0_error : req1_error;
            end
            tick();
        end
    endtask

    logic        acc, err, stray;
    logic [29:0] a1;
    logic [31:0] wd, rd;
    int          wc, dc;

    task automatic test_reset();
        reset = 1; idle_inputs(); poke_en = 0;
        req0_valid = 1; req1_valid = 1;
        tick(); tick();
        tests_run++;
        if ({req0_ready, req1_ready, req0_done, req1_done, req0_error, req1_error, backendWriteEnable} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {req0_ready, req1_ready, req0_done, req1_done, req0_error, req1_error, backendWriteEnable});
        end
        tests_run++;
        if ({req0_rdata, req1_rdata} !== 64'h0) begin
            tests_failed++; $display("FAIL reset_rdata: got %h %h expected 0", req0_rdata, req1_rdata);
        end
        tests_run++;
        if (backendAddress !== 30'h0 || backendDataIn !== 32'h0) begin
            tests_failed++; $display("FAIL reset_backend: got addr %h data %h expected 0", backendAddress, backendDataIn);
        end
        idle_inputs();
        tick();
        reset = 0;
        tick();
    endtask

    task automatic test_byte_load();
        poke(8'h40, 32'h80FF_1234);
        run_access(0, 32'h103, 0, 2'd0, 0, 32'h0, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (acc !== 1'b1) begin tests_failed++; $display("FAIL lb_ready: got %b expected 1", acc); end
        tests_run++; if (a1 !== 30'h40) begin tests_failed++; $display("FAIL lb_addr: got %h expected 40", a1); end
        tests_run++; if (dc != 3) begin tests_failed++; $display("FAIL lb_done_cycle: got %0d expected 3", dc); end
        tests_run++; if (rd !== 32'hFFFF_FF80) begin tests_failed++; $display("FAIL lb_rdata: got %h expected ffffff80", rd); end
        tests_run++; if (err !== 1'b0 || wc != -1 || stray !== 1'b0) begin
            tests_failed++; $display("FAIL lb_side: got err %b we_cycle %0d stray %b expected 0 -1 0", err, wc, stray);
        end
        run_access(0, 32'h102, 0, 2'd0, 1, 32'h0, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (rd !== 32'h0000_00FF || dc != 3) begin
            tests_failed++; $display("FAIL lbu_rdata: got %h at %0d expected 000000ff at 3", rd, dc);
        end
    endtask

    task automatic test_half_store();
        poke(8'h80, 32'h1122_3344);
        run_access(1, 32'h202, 1, 2'd1, 0, 32'h0000_BEEF, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (acc !== 1'b1) begin tests_failed++; $display("FAIL sh_ready: got %b expected 1", acc); end
        tests_run++; if (wc != 3) begin tests_failed++; $display("FAIL sh_we_cycle: got %0d expected 3", wc); end
        tests_run++; if (wd !== 32'hBEEF_3344) begin tests_failed++; $display("FAIL sh_wdata: got %h expected beef3344", wd); end
        tests_run++; if (dc != 4 || err !== 1'b0 || stray !== 1'b0) begin
            tests_failed++; $display("FAIL sh_done: got cycle %0d err %b stray %b expected 4 0 0", dc, err, stray);
        end
        tests_run++; if (mem[8'h80] !== 32'hBEEF_3344) begin
            tests_failed++; $display("FAIL sh_mem: got %h expected beef3344", mem[8'h80]);
        end
        run_access(1, 32'h202, 0, 2'd1, 0, 32'h0, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (rd !== 32'hFFFF_BEEF || dc != 3) begin
            tests_failed++; $display("FAIL lh_rdata: got %h at %0d expected ffffbeef at 3", rd, dc);
        end
        run_access(1, 32'h200, 0, 2'd1, 1, 32'h0, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (rd !== 32'h0000_3344) begin tests_failed++; $display("FAIL lhu_rdata: got %h expected 00003344", rd); end
    endtask

    task automatic test_word_store();
        run_access(0, 32'h10, 1, 2'd2, 0, 32'hDEAD_BEEF, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (a1 !== 30'h4) begin tests_failed++; $display("FAIL sw_addr: got %h expected 4", a1); end
        tests_run++; if (wc != 1 || wd !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL sw_write: got cycle %0d data %h expected 1 deadbeef", wc, wd);
        end
        tests_run++; if (dc != 2) begin tests_failed++; $display("FAIL sw_done_cycle: got %0d expected 2", dc); end
        tests_run++; if (mem[8'h04] !== 32'hDEAD_BEEF) begin
            tests_failed++; $display("FAIL sw_mem: got %h expected deadbeef", mem[8'h04]);
        end
    endtask

    task automatic test_misaligned();
        poke(8'h01, 32'hCAFE_F00D);
        run_access(0, 32'h06, 0, 2'd2, 0, 32'h0, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (dc != 1 || err !== 1'b1) begin
            tests_failed++; $display("FAIL mis_word: got cycle %0d err %b expected 1 1", dc, err);
        end
        tests_run++; if (wc != -1 || rd !== 32'h0) begin
            tests_failed++; $display("FAIL mis_word_side: got we_cycle %0d rdata %h expected -1 0", wc, rd);
        end
        run_access(1, 32'h05, 1, 2'd1, 0, 32'h0000_1111, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (dc != 1 || err !== 1'b1 || wc != -1) begin
            tests_failed++; $display("FAIL mis_half: got cycle %0d err %b we_cycle %0d expected 1 1 -1", dc, err, wc);
        end
        run_access(1, 32'h20, 0, 2'd3, 0, 32'h0, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (dc != 1 || err !== 1'b1) begin
            tests_failed++; $display("FAIL mis_size3: got cycle %0d err %b expected 1 1", dc, err);
        end
        tests_run++; if (mem[8'h01] !== 32'hCAFE_F00D) begin
            tests_failed++; $display("FAIL mis_mem: got %h expected cafef00d", mem[8'h01]);
        end
    endtask

    task automatic test_reset_in_writeback();
        poke(8'h10, 32'h5566_7788);
        req0_valid = 1; req0_address = 32'h41; req0_write = 1; req0_size = 2'd0; req0_unsigned = 0; req0_wdata = 32'hAB;
        #1;
        tests_run++; if (req0_ready !== 1'b1) begin tests_failed++; $display("FAIL rwb_ready: got %b expected 1", req0_ready); end
        tick();
        req0_valid = 0;
        tick(); tick();
        tests_run++; if (backendWriteEnable !== 1'b1 || backendDataIn !== 32'h5566_AB88) begin
            tests_failed++; $display("FAIL rwb_merge: got we %b data %h expected 1 5566ab88", backendWriteEnable, backendDataIn);
        end
        reset = 1;
        #1;
        tests_run++; if (backendWriteEnable !== 1'b0) begin tests_failed++; $display("FAIL rwb_gate: got %b expected 0", backendWriteEnable); end
        tick();
        tests_run++; if (req0_done !== 1'b0 || req1_done !== 1'b0) begin
            tests_failed++; $display("FAIL rwb_no_done: got %b %b expected 0 0", req0_done, req1_done);
        end
        reset = 0;
        run_access(1, 32'h40, 0, 2'd2, 0, 32'h0, acc, a1, wc, wd, dc, rd, err, stray);
        tests_run++; if (acc !== 1'b1) begin tests_failed++; $display("FAIL rwb_idle: got ready %b expected 1", acc); end
        tests_run++; if (rd !== 32'h5566_7788 || mem[8'h10] !== 32'h5566_7788) begin
            tests_failed++; $display("FAIL rwb_mem: got rdata %h mem %h expected 55667788", rd, mem[8'h10]);
        end
        tests_run++; if (stray !== 1'b0) begin tests_failed++; $display("FAIL rwb_stray: got %b expected 0", stray); end
    endtask

    task automatic test_arbitration();
        int grants[4];
        int exp_grants[4];
        int n_exp;
        int n;
        logic both;
`ifdef MEMORY_ARBITER_ROUND_ROBIN_EN
        exp_grants = '{0, 1, 0, 1};
        n_exp = 4;
`else
        exp_grants = '{0, 0, 0, 0};
        n_exp = 3;
`endif
        n = 0; both = 0; grants = '{-1, -1, -1, -1};
        reset = 1;
        req0_valid = 1; req0_address = 32'h0; req0_write = 0; req0_size = 2'd2; req0_unsigned = 0;
        req1_valid = 1; req1_address = 32'h4; req1_write = 0; req1_size = 2'd2; req1_unsigned = 0;
        tick(); tick();
        reset = 0;
        #1;
        for (int c = 0; c < 60 && n < n_exp; c++) begin
            if (req0_ready && req1_ready) both = 1;
            if (req0_ready)      begin grants[n] = 0; n++; end
            else if (req1_ready) begin grants[n] = 1; n++; end
            tick();
        end
        idle_inputs();
        tests_run++; if (n != n_exp) begin tests_failed++; $display("FAIL arb_count: got %0d grants expected %0d", n, n_exp); end
        tests_run++; if (both !== 1'b0) begin tests_failed++; $display("FAIL arb_exclusive: got both ready %b expected 0", both); end
        for (int i = 0; i < n_exp; i++) begin
            tests_run++;
            if (grants[i] != exp_grants[i]) begin
                tests_failed++; $display("FAIL arb_grant%0d: got %0d expected %0d", i, grants[i], exp_grants[i]);
            end
        end
        for (int c = 0; c < 6; c++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        test_reset();
        test_byte_load();
        test_half_store();
        test_word_store();
        test_misaligned();
        test_reset_in_writeback();
        test_arbitration();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
